stopwatch_bcd: RTL



---
 rtl/stopwatch_bcd_pkg.sv | 30 +++
 rtl/stopwatch_bcd_if.sv | 36 +++
 rtl/bcd_digit_counter.sv | 43 ++++
 rtl/stopwatch_bcd.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the stopwatch_bcd slice.
//   state_t    : run-control FSM states (IDLE, RUN, PAUSE)
//   bcd_t      : one BCD digit (DIGIT_W bits)
//   bcd_time_t : a full MM:SS.cc value, minutes tens in the top nibble
//   DIGIT_MAX_9 / DIGIT_MAX_5 : digit roll-over limits
package stopwatch_bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t DIGIT_MAX_9 = 4'd9;
    localparam bcd_t DIGIT_MAX_5 = 4'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        bcd_t m_tens;
        bcd_t m_ones;
        bcd_t s_tens;
        bcd_t s_ones;
        bcd_t cs_tens;
        bcd_t cs_ones;
    } bcd_time_t;

endpackage

// File: rtl/stopwatch_bcd_if.sv
// Signal bundle between the stopwatch core and its environment.
//   tick_in                         : 100 Hz divided clock, treated as data
//   btn_start / btn_clear / btn_lap : debounced CLK_50-synchronous levels
//   cs_*, s_*, m_*                  : displayed BCD digits
//   running / frozen / wrapped      : status flags
// master drives the controls and observes the display; slave is the core.
interface stopwatch_bcd_if;
    import stopwatch_bcd_pkg::*;

    logic tick_in;
    logic btn_start;
    logic btn_clear;
    logic btn_lap;
    bcd_t cs_ones;
    bcd_t cs_tens;
    bcd_t s_ones;
    bcd_t s_tens;
    bcd_t m_ones;
    bcd_t m_tens;
    logic running;
    logic frozen;
    logic wrapped;

    modport master (
        output tick_in, btn_start, btn_clear, btn_lap,
        input  cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
        input  running, frozen, wrapped
    );

    modport slave (
        input  tick_in, btn_start, btn_clear, btn_lap,
        output cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens,
        output running, frozen, wrapped
    );

endinterface

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter that rolls over to 0 after MAX.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over inc)
//   inc      : advance by one
//   digit    : current digit value
//   carry    : inc while at MAX, i.e. this digit is rolling over
module bcd_digit_counter
    import stopwatch_bcd_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX_9
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output bcd_t digit,
    output logic carry
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS.cc BCD stopwatch driven by a 100 Hz tick sampled as data.
//   CLK_50 : 50 MHz system clock
//   RESET  : asynchronous, active-high reset
//   sw     : stopwatch_bcd_if.slave - tick_in and button levels in,
//            displayed digits plus running/frozen/wrapped out
// tick_in goes through SYNC_STAGES synchroniser flops and a rising-edge
// detector; buttons are edge-detected; a 3-state FSM gates counting.
// Minutes roll over after MIN_MAX:59.99 and set the sticky wrapped flag.
module stopwatch_bcd
    import stopwatch_bcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_MAX     = 59
) (
    input  logic           CLK_50,
    input  logic           RESET,
    stopwatch_bcd_if.slave sw
);

    localparam bcd_t MIN_TENS = 4'(MIN_MAX / 10);
    localparam bcd_t MIN_ONES = 4'(MIN_MAX % 10);

    // input conditioning
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   tick_prev_q, tick_prev_d;
    logic [2:0]             btn_prev_q, btn_prev_d;
    logic                   tick;
    logic                   start_e, clear_e, lap_e;

    // control
    state_t    state_q, state_d;
    logic      running_q, running_d;
    logic      frozen_q, frozen_d;
    logic      wrapped_q, wrapped_d;
    bcd_time_t lap_q, lap_d;
    bcd_time_t disp_q, disp_d;
    logic      clear_go;
    logic      inc_cnt;
    logic      wrap_evt;
    logic      min_clr;

    // live count
    bcd_t      cs_ones, cs_tens, s_ones, s_tens, m_ones, m_tens;
    logic      c_cs_ones, c_cs_tens, c_s_ones, c_s_tens, c_m_ones, c_m_tens;
    bcd_time_t live;

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], sw.tick_in};
        tick_prev_d = sync_q[SYNC_STAGES-1];
        btn_prev_d  = {sw.btn_lap, sw.btn_clear, sw.btn_start};
    end

    assign tick    = sync_q[SYNC_STAGES-1] & ~tick_prev_q;
    assign start_e = sw.btn_start & ~btn_prev_q[0];
    assign clear_e = sw.btn_clear & ~btn_prev_q[1];
    assign lap_e   = sw.btn_lap   & ~btn_prev_q[2];

    // Counting is gated by the pre-transition state, so a tick landing on
    // RUN->PAUSE counts while one landing on PAUSE->RUN does not.
    assign inc_cnt = tick & (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        clear_go = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_e) begin
                    clear_go = 1'b1;
                end else if (start_e) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (start_e) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (clear_e) begin
                    clear_go = 1'b1;
                    state_d  = IDLE;
                end else if (start_e) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Seconds are rolling over from 59.99 with minutes at their limit.
    // A minutes-tens overflow can only occur when MIN_MAX is 99, where it
    // coincides with the limit check anyway.
    assign wrap_evt = (c_s_tens & (m_tens == MIN_TENS) & (m_ones == MIN_ONES))
                      | c_m_tens;
    assign min_clr  = clear_go | wrap_evt;

    always_comb begin
        live      = '{m_tens: m_tens, m_ones: m_ones, s_tens: s_tens,
                      s_ones: s_ones, cs_tens: cs_tens, cs_ones: cs_ones};
        running_d = (state_d == RUN);
        frozen_d  = frozen_q;
        lap_d     = lap_q;
        wrapped_d = wrapped_q;

        if (clear_go) begin
            frozen_d = 1'b0;
        end else if (lap_e) begin
            if (frozen_q && state_q != IDLE) begin
                frozen_d = 1'b0;
            end else if (!frozen_q && state_q == RUN) begin
                frozen_d = 1'b1;
                lap_d    = live;   // pre-increment value
            end
        end

        if (clear_go) begin
            wrapped_d = 1'b0;
        end else if (wrap_evt) begin
            wrapped_d = 1'b1;
        end

        disp_d = frozen_q ? lap_q : live;
    end

    always_ff @(posedge CLK_50 or posedge RESET) begin
        if (RESET) begin
            sync_q      <= '0;
            tick_prev_q <= 1'b0;
            btn_prev_q  <= '0;
            state_q     <= IDLE;
            running_q   <= 1'b0;
            frozen_q    <= 1'b0;
            wrapped_q   <= 1'b0;
            lap_q       <= '0;
            disp_q      <= '0;
        end else begin
            sync_q      <= sync_d;
            tick_prev_q <= tick_prev_d;
            btn_prev_q  <= btn_prev_d;
            state_q     <= state_d;
            running_q   <= running_d;
            frozen_q    <= frozen_d;
            wrapped_q   <= wrapped_d;
            lap_q       <= lap_d;
            disp_q      <= disp_d;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_ones (
        .clk(CLK_50), .rst(RESET), .clr(clear_go), .inc(inc_cnt),
        .digit(cs_ones), .carry(c_cs_ones));
    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_cs_tens (
        .clk(CLK_50), .rst(RESET), .clr(clear_go), .inc(c_cs_ones),
        .digit(cs_tens), .carry(c_cs_tens));
    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_s_ones (
        .clk(CLK_50), .rst(RESET), .clr(clear_go), .inc(c_cs_tens),
        .digit(s_ones), .carry(c_s_ones));
    bcd_digit_counter #(.MAX(DIGIT_MAX_5)) u_s_tens (
        .clk(CLK_50), .rst(RESET), .clr(clear_go), .inc(c_s_ones),
        .digit(s_tens), .carry(c_s_tens));
    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_m_ones (
        .clk(CLK_50), .rst(RESET), .clr(min_clr), .inc(c_s_tens),
        .digit(m_ones), .carry(c_m_ones));
    bcd_digit_counter #(.MAX(DIGIT_MAX_9)) u_m_tens (
        .clk(CLK_50), .rst(RESET), .clr(min_clr), .inc(c_m_ones),
        .digit(m_tens), .carry(c_m_tens));

    assign sw.cs_ones = disp_q.cs_ones;
    assign sw.cs_tens = disp_q.cs_tens;
    assign sw.s_ones  = disp_q.s_ones;
    assign sw.s_tens  = disp_q.s_tens;
    assign sw.m_ones  = disp_q.m_ones;
    assign sw.m_tens  = disp_q.m_tens;
    assign sw.running = running_q;
    assign sw.frozen  = frozen_q;
    assign sw.wrapped = wrapped_q;

endmodule
